// File: rtl/carry_look_ahead_adder_4bit_pkg.sv
// Shared constants and elaboration helpers for the carry-lookahead adder family.
// The slice width is fixed at 4. Wider adders are built from whole slices.
package adder_pkg;

    localparam int GROUP_W = 4;

    // True when w can be tiled exactly by 4-bit lookahead slices.
    function automatic bit width_ok(input int w);
        return (w > 0) && ((w % GROUP_W) == 0);
    endfunction

endpackage

// File: rtl/carry_look_ahead_adder_4bit_if.sv
// Operand/result bundle for the registered carry-lookahead adder.
// There is no handshake: operands are sampled on every rising edge and the
// result is valid one cycle later. p_out/g_out are combinational from a/b.
interface carry_look_ahead_adder_4bit_if #(
    parameter int WIDTH = 4
);

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic [WIDTH-1:0] s;
    logic             c_out;
    logic             p_out;
    logic             g_out;

    modport master (
        output a,
        output b,
        output c_in,
        input  s,
        input  c_out,
        input  p_out,
        input  g_out
    );

    modport slave (
        input  a,
        input  b,
        input  c_in,
        output s,
        output c_out,
        output p_out,
        output g_out
    );

endinterface

// File: rtl/carry_look_ahead_adder_4bit_cla_group4.sv
// Purely combinational 4-bit carry-lookahead slice.
// Exports group propagate/generate for a second lookahead level above it.
module cla_group4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       gp,
    output logic       gg
);

    logic [3:0] p;
    logic [3:0] g;
    logic       c1;
    logic       c2;
    logic       c3;

    assign p = a ^ b;
    assign g = a & b;

    // Each carry is a flat sum of products so depth stays constant per bit.
    assign c1 = g[0]
              | (p[0] & cin);
    assign c2 = g[1]
              | (p[1] & g[0])
              | (p[1] & p[0] & cin);
    assign c3 = g[2]
              | (p[2] & g[1])
              | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);

    assign s = p ^ {c3, c2, c1, cin};

    assign gp = p[3] & p[2] & p[1] & p[0];
    assign gg = g[3]
              | (p[3] & g[2])
              | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]);

endmodule

// File: rtl/carry_look_ahead_adder_4bit.sv
// Registered carry-lookahead adder: WIDTH/4 slices joined by a second lookahead
// level, with {c_out, s} registered and p_out/g_out left combinational.
module carry_look_ahead_adder_4bit
    import adder_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    carry_look_ahead_adder_4bit_if.slave  bus
);

    localparam int NG = WIDTH / GROUP_W;

    if (!width_ok(WIDTH)) begin : g_width_check
        $error("carry_look_ahead_adder_4bit: WIDTH must be a positive multiple of 4");
    end

    // Carry into group j from the group terms below it. Every j is computed
    // independently and flattens to one AND-OR level over (GP, GG).
    function automatic logic carry_into(
        input logic [NG-1:0] gp_v,
        input logic [NG-1:0] gg_v,
        input logic          cin_v,
        input int            j
    );
        logic acc;
        logic run;
        acc = 1'b0;
        run = 1'b1;
        for (int k = j - 1; k >= 0; k--) begin
            acc = acc | (run & gg_v[k]);
            run = run & gp_v[k];
        end
        acc = acc | (run & cin_v);
        return acc;
    endfunction

    logic [NG-1:0]    gp;
    logic [NG-1:0]    gg;
    logic [NG:0]      gc;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] s_q;
    logic             c_out_q;

    assign gc[0] = bus.c_in;

    for (genvar j = 0; j < NG; j++) begin : g_grp
        cla_group4 u_grp (
            .a   (bus.a[GROUP_W*j +: GROUP_W]),
            .b   (bus.b[GROUP_W*j +: GROUP_W]),
            .cin (gc[j]),
            .s   (sum[GROUP_W*j +: GROUP_W]),
            .gp  (gp[j]),
            .gg  (gg[j])
        );
        assign gc[j+1] = carry_into(gp, gg, bus.c_in, j + 1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q     <= '0;
            c_out_q <= 1'b0;
        end else begin
            s_q     <= sum;
            c_out_q <= gc[NG];
        end
    end

    assign bus.s     = s_q;
    assign bus.c_out = c_out_q;
    assign bus.p_out = &gp;
    assign bus.g_out = carry_into(gp, gg, 1'b0, NG);

endmodule

// File: tb/tb_carry_look_ahead_adder_4bit.sv
// Directed and exhaustive bench for the registered carry-lookahead adder,
// exercising a 4-bit and an 8-bit instance side by side.
module tb_carry_look_ahead_adder_4bit;

  logic clk;
  logic rst_n;
  logic cmp_en;
  int   n_vec;
  int   n_err;

  logic [4:0] exp4;
  logic [8:0] exp8;

  carry_look_ahead_adder_4bit_if #(.WIDTH(4)) i4 ();
  carry_look_ahead_adder_4bit_if #(.WIDTH(8)) i8 ();

  carry_look_ahead_adder_4bit #(.WIDTH(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (i4.slave)
  );

  carry_look_ahead_adder_4bit #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (i8.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model: the register holds the arithmetic sum of the operands seen at the last edge
  always @(posedge clk) begin
    if (rst_n) begin
      exp4 <= {1'b0, i4.a} + {1'b0, i4.b} + {4'b0, i4.c_in};
      exp8 <= {1'b0, i8.a} + {1'b0, i8.b} + {8'b0, i8.c_in};
    end
  end

  always @(negedge rst_n) begin
    exp4 <= '0;
    exp8 <= '0;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // compare process: registered outputs against the model, group terms against plain arithmetic
  always @(negedge clk) begin
    if (cmp_en) begin
      logic [4:0] raw4;
      logic [8:0] raw8;
      raw4 = {1'b0, i4.a} + {1'b0, i4.b};
      raw8 = {1'b0, i8.a} + {1'b0, i8.b};
      chk("sum4", int'({i4.c_out, i4.s}), rst_n ? int'(exp4) : 0);
      chk("p4",   int'(i4.p_out), int'(&(i4.a ^ i4.b)));
      chk("g4",   int'(i4.g_out), int'(raw4[4]));
      chk("sum8", int'({i8.c_out, i8.s}), rst_n ? int'(exp8) : 0);
      chk("p8",   int'(i8.p_out), int'(&(i8.a ^ i8.b)));
      chk("g8",   int'(i8.g_out), int'(raw8[8]));
    end
  end

  // driver: set inputs, let one edge capture them, return 2 time units after it
  task automatic set_in(input logic [3:0] a4, input logic [3:0] b4, input logic c,
                        input logic [7:0] a8, input logic [7:0] b8);
    i4.a = a4; i4.b = b4; i4.c_in = c;
    i8.a = a8; i8.b = b8; i8.c_in = c;
  endtask

  task automatic vec(input logic [3:0] a4, input logic [3:0] b4, input logic c,
                     input logic [7:0] a8, input logic [7:0] b8);
    set_in(a4, b4, c, a8, b8);
    @(posedge clk);
    #2;
  endtask

  initial begin
    n_vec  = 0;
    n_err  = 0;
    cmp_en = 1'b0;
    exp4   = '0;
    exp8   = '0;
    rst_n  = 1'b1;
    set_in(4'd15, 4'd15, 1'b1, 8'd15, 8'd15);
    #1 rst_n = 1'b0;

    // reset forces zero without any clock edge
    #2;
    chk("rst_s4_noclk",    int'(i4.s), 0);
    chk("rst_cout4_noclk", int'(i4.c_out), 0);
    chk("rst_sum8_noclk",  int'({i8.c_out, i8.s}), 0);
    @(posedge clk);
    #2;
    chk("rst_sum4_held", int'({i4.c_out, i4.s}), 0);
    rst_n = 1'b1;
    #1;
    chk("rst_sum4_released_noedge", int'({i4.c_out, i4.s}), 0);
    @(posedge clk);
    #2;
    chk("first_edge_s4",    int'(i4.s), 15);
    chk("first_edge_cout4", int'(i4.c_out), 1);
    chk("first_edge_sum8",  int'({i8.c_out, i8.s}), 30 + 1);
    cmp_en = 1'b1;

    // latency and hold
    vec(4'd3, 4'd4, 1'b0, 8'd255, 8'd1);
    chk("lat_s4", int'({i4.c_out, i4.s}), 7);
    chk("w8_255_1_s", int'(i8.s), 0);
    chk("w8_255_1_c", int'(i8.c_out), 1);
    set_in(4'd9, 4'd9, 1'b1, 8'd128, 8'd127);
    #1;
    chk("hold_s4", int'({i4.c_out, i4.s}), 7);
    @(posedge clk);
    #2;
    chk("lat2_sum4", int'({i4.c_out, i4.s}), 19);
    chk("w8_128_127_s", int'(i8.s), 0);
    chk("w8_128_127_c", int'(i8.c_out), 1);

    // mid-cycle glitch leaves the registers alone
    set_in(4'd0, 4'd0, 1'b0, 8'd0, 8'd0);
    #1;
    chk("glitch_sum4", int'({i4.c_out, i4.s}), 19);
    set_in(4'd2, 4'd5, 1'b0, 8'd200, 8'd100);

    // reset between edges drops the held result immediately
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_sum4", int'({i4.c_out, i4.s}), 0);
    chk("midrst_sum8", int'({i8.c_out, i8.s}), 0);
    #1 rst_n = 1'b1;
    #1;
    chk("midrst_release_sum4", int'({i4.c_out, i4.s}), 0);
    @(posedge clk);
    #2;
    chk("after_rst_sum4", int'({i4.c_out, i4.s}), 7);
    chk("after_rst_sum8", int'({i8.c_out, i8.s}), 300);

    // carry chain
    vec(4'd7, 4'd8, 1'b1, 8'h7F, 8'h80);
    chk("chain_s4",    int'(i4.s), 0);
    chk("chain_cout4", int'(i4.c_out), 1);
    chk("chain_p4",    int'(i4.p_out), 1);
    chk("chain_g4",    int'(i4.g_out), 0);
    chk("chain_sum8",  int'({i8.c_out, i8.s}), 256);
    chk("chain_p8",    int'(i8.p_out), 1);
    vec(4'd15, 4'd0, 1'b0, 8'hF0, 8'h10);
    chk("f0_s4",    int'(i4.s), 15);
    chk("f0_cout4", int'(i4.c_out), 0);
    chk("f0_g8",    int'(i8.g_out), 1);

    // exhaustive 4-bit space; the 8-bit instance sees nibble-swapped operands
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int c = 0; c < 2; c++) begin
          logic [3:0] av;
          logic [3:0] bv;
          av = a[3:0];
          bv = b[3:0];
          vec(av, bv, c[0], {av, bv}, {bv, av});
        end
      end
    end

    repeat (2) @(posedge clk);
    #2;
    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/carry_look_ahead_adder_4bit.md
# carry_look_ahead_adder_4bit

Registered carry-lookahead adder: computes a + b + c_in with two-level generate/propagate lookahead and presents {c_out, s} from output registers one clock after the operands are sampled. Default width is 4 bits. It also exports combinational group propagate and generate terms, so several instances can be cascaded under an external lookahead unit to build wider adders.

## Interface
- WIDTH, 4: operand width; must be a positive multiple of 4 (elaboration error otherwise)
- clk  input  1  single clock; all state rising-edge triggered
- rst_n  input  1  asynchronous, active-low reset
- a  input  WIDTH  operand A, unsigned
- b  input  WIDTH  operand B, unsigned
- c_in  input  1  carry in, weight 1
- s  output  WIDTH  registered sum, low WIDTH bits of a + b + c_in
- c_out  output  1  registered carry out, bit WIDTH of a + b + c_in
- p_out  output  1  combinational group propagate, AND of all bit propagates (a[i] ^ b[i])
- g_out  output  1  combinational group generate, 1 when a + b alone carries out regardless of c_in

## Operation
- Bit terms: p[i] = a[i] ^ b[i], g[i] = a[i] & b[i].
- Per 4-bit group, carries use lookahead, not ripple:
  - c1 = g0 | p0·cin
  - c2 = g1 | p1·g0 | p1·p0·cin
  - and so on through c4
- Group GP = p3·p2·p1·p0.
- Group GG = g3 | p3·g2 | p3·p2·g1 | p3·p2·p1·g0.
- Groups combine through a second lookahead level over (GP, GG), not by ripple between groups.
- Sum bits: s[i] = p[i] ^ c[i].
- Next state: {c_out, s} <= a + b + c_in, exact for all 2^(2·WIDTH+1) input combinations. The arithmetic result is WIDTH+1 bits, so no overflow is lost.
- p_out and g_out reflect the current a and b with no register and no dependence on c_in or reset.
- There is no enable. The output register loads on every rising clk edge.

## Timing
- Latency is 1 cycle. Operands stable before rising edge N produce the result on {c_out, s} after edge N, and it holds until edge N+1.
- Reset: rst_n low immediately forces s = 0 and c_out = 0, without waiting for clk.
- Reset release: the first edge with rst_n high loads a valid result.
- Reset mid-operation discards the pending result. Nothing is replayed after release.
- Inputs changing between edges do not affect s or c_out until the next edge.
- p_out and g_out follow the inputs combinationally, within the same cycle.
- The critical path is operand to register through two lookahead levels. Depth must not grow linearly with WIDTH within a group.

## Structure
- Shared package adder_pkg holds:
  - the GROUP_W = 4 constant
  - a width-check function used for the WIDTH assertion
- Sub-module cla_group4: a purely combinational 4-bit CLA slice.
  - Inputs: a[3:0], b[3:0], cin.
  - Outputs: s[3:0], gp, gg.
- The top level contains:
  - a generate loop of WIDTH/4 cla_group4 instances
  - the second-level carry lookahead
  - the output register with asynchronous reset
- The top-level p_out and g_out are the second-level group terms.

## Test plan
- Reset: hold rst_n = 0 with a = 15, b = 15, c_in = 1 -> s = 0, c_out = 0 throughout, with no clock edge needed. Release rst_n, then after 1 edge -> s = 15, c_out = 1.
- Exhaustive, WIDTH = 4: every a, b in 0..15 and c_in in 0..1 (512 cases), one vector per cycle -> {c_out, s} equals a + b + c_in one cycle later. Bench counts errors and expects 0.
- Carry chain, WIDTH = 4:
  - a = 7, b = 8, c_in = 1 -> s = 0, c_out = 1, p_out = 1, g_out = 0.
  - a = 15, b = 0, c_in = 0 -> s = 15, c_out = 0.
- Latency and hold: a = 3, b = 4, c_in = 0 on edge N, then a = 9, b = 9, c_in = 1 on edge N+1 -> s = 7 after N, {c_out, s} = 19 after N+1. Mid-cycle input glitches leave the outputs unchanged.
- Reset mid-stream: assert rst_n between edges while the output is 19 -> output goes to 0 immediately. After release, the next edge loads the current inputs.
- WIDTH = 8: a = 255, b = 1, c_in = 0 -> s = 0, c_out = 1. a = 128, b = 127, c_in = 1 -> s = 0, c_out = 1.
